// File: rtl/data_stack_unit.sv
// Byte-wide LIFO data stack between the ALU result and the ALU source mux.
// The top of stack is kept in its own register so the ALU never waits on an
// array read. Status outputs give empty/full, a depth count and sticky error flags.
module data_stack_unit #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [7:0]    data_in,
  output logic [7:0]    stack_out,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] OneC   = CW'(1);
  localparam logic [CW-1:0] TwoC   = CW'(2);

  logic [7:0]    mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    top_q, top_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [AW-1:0] below_idx;

  // Entry just under the current top; only meaningful when count_q >= 2.
  assign below_idx = AW'(count_q - TwoC);

  // Decode the prioritised command into next state and an array write.
  always_comb begin
    count_d   = count_q;
    top_d     = top_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = AW'(count_q);
    if (clear) begin
      count_d = '0;
      top_d   = 8'h00;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (push && pop) begin
      if (count_q != '0) begin
        // Replace the top in place; legal even when full.
        mem_we    = 1'b1;
        mem_waddr = AW'(count_q - OneC);
        top_d     = data_in;
      end else begin
        // Nothing to discard: behave as a plain push and flag the bad pop.
        mem_we    = 1'b1;
        mem_waddr = '0;
        count_d   = OneC;
        top_d     = data_in;
        unf_d     = 1'b1;
      end
    end else if (push) begin
      if (count_q != DepthC) begin
        mem_we  = 1'b1;
        count_d = count_q + OneC;
        top_d   = data_in;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pop) begin
      if (count_q >= TwoC) begin
        count_d = count_q - OneC;
        top_d   = mem_q[below_idx];
      end else if (count_q == OneC) begin
        count_d = '0;
        top_d   = 8'h00;
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  // Control and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      top_q   <= 8'h00;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array; contents are don't-care after reset or clear.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= data_in;
    end
  end

  assign stack_out = top_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == DepthC);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_data_stack_unit.sv
// Self-checking bench for data_stack_unit: directed scenarios followed by
// random traffic, all compared against a queue-based LIFO model.
module tb_data_stack_unit;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          push, pop, clear;
  logic [7:0]    data_in;
  logic [7:0]    stack_out;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow;

  int errors = 0;
  int checks = 0;

  // Reference model: queue whose last element is the top of stack.
  logic [7:0] model_q[$];
  bit         m_ovf, m_unf;

  always #5 clock = ~clock;

  data_stack_unit #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .data_in   (data_in),
    .stack_out (stack_out),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_apply(input bit p, input bit o, input bit c, input logic [7:0] d);
    if (c) begin
      model_reset();
    end else if (p && o) begin
      if (model_q.size() > 0) model_q[model_q.size()-1] = d;
      else begin
        model_q.push_back(d);
        m_unf = 1'b1;
      end
    end else if (p) begin
      if (model_q.size() < DEPTH) model_q.push_back(d);
      else m_ovf = 1'b1;
    end else if (o) begin
      if (model_q.size() > 0) void'(model_q.pop_back());
      else m_unf = 1'b1;
    end
  endtask

  task automatic check_all(input string ctx);
    logic [7:0] exp_top;
    int n;
    n       = model_q.size();
    exp_top = (n > 0) ? model_q[n-1] : 8'h00;
    chk({ctx, ".stack_out"}, 32'(stack_out), 32'(exp_top));
    chk({ctx, ".count"}, 32'(count), 32'(n));
    chk({ctx, ".empty"}, 32'(empty), 32'(n == 0));
    chk({ctx, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({ctx, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({ctx, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // Drive one command across a rising edge and check outputs at the falling edge.
  task automatic cmd(input string ctx, input bit p, input bit o, input bit c,
                     input logic [7:0] d);
    push    = p;
    pop     = o;
    clear   = c;
    data_in = d;
    @(posedge clock);
    model_apply(p, o, c, d);
    @(negedge clock);
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
    check_all(ctx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    data_in = 8'h00;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Three pushes then three pops.
    cmd("push_a1", 1, 0, 0, 8'hA1);
    chk("push_a1.top_const", 32'(stack_out), 32'hA1);
    cmd("push_b2", 1, 0, 0, 8'hB2);
    cmd("push_c3", 1, 0, 0, 8'hC3);
    chk("push_c3.count_const", 32'(count), 32'd3);
    cmd("pop1", 0, 1, 0, 8'h00);
    chk("pop1.top_const", 32'(stack_out), 32'hB2);
    cmd("pop2", 0, 1, 0, 8'h00);
    cmd("pop3", 0, 1, 0, 8'h00);
    chk("pop3.empty_const", 32'(empty), 32'd1);

    // Fill, overflow, then replace-top while full.
    for (int i = 0; i < DEPTH; i++) cmd("fill", 1, 0, 0, 8'(i));
    chk("fill.full_const", 32'(full), 32'd1);
    chk("fill.top_const", 32'(stack_out), 32'h0F);
    cmd("overflow_push", 1, 0, 0, 8'hFF);
    chk("overflow.flag_const", 32'(overflow), 32'd1);
    chk("overflow.top_const", 32'(stack_out), 32'h0F);
    cmd("replace_full", 1, 1, 0, 8'h55);
    chk("replace_full.top_const", 32'(stack_out), 32'h55);
    chk("replace_full.count_const", 32'(count), 32'd16);

    // Pop down to 3 while keeping overflow set, then reset asynchronously mid-cycle.
    for (int i = 0; i < 13; i++) cmd("drain", 0, 1, 0, 8'h00);
    chk("drain.count_const", 32'(count), 32'd3);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    cmd("post_reset_push", 1, 0, 0, 8'h3C);
    chk("post_reset.count_const", 32'(count), 32'd1);

    // Underflow on empty, then push+pop on empty.
    cmd("clear0", 0, 0, 1, 8'h00);
    cmd("underflow_pop", 0, 1, 0, 8'h00);
    chk("underflow.flag_const", 32'(underflow), 32'd1);
    cmd("pushpop_empty", 1, 1, 0, 8'h7E);
    chk("pushpop_empty.top_const", 32'(stack_out), 32'h7E);
    chk("pushpop_empty.unf_const", 32'(underflow), 32'd1);

    // clear has priority over push.
    for (int i = 0; i < 4; i++) cmd("to_five", 1, 0, 0, 8'(8'h20 + i));
    chk("to_five.count_const", 32'(count), 32'd5);
    cmd("clear_push", 1, 0, 1, 8'h99);
    chk("clear_push.count_const", 32'(count), 32'd0);
    chk("clear_push.unf_const", 32'(underflow), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit p, o, c;
      c = ($urandom_range(0, 99) < 3);
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 45);
      cmd("random", p, o, c, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_stack_unit.md
# data_stack_unit

Byte-wide LIFO data stack that sits directly downstream of the ALU unit and loops back into it. It captures the ALU result on push and presents the current top of stack on `stack_out`, which feeds the ALU source mux's stack input. It provides full/empty status, a depth count, and sticky overflow/underflow error flags for the control unit.

## Interface
- `DEPTH`, default 16: number of byte entries; must be a power of two, ≥ 2.
- `CW`, default $clog2(DEPTH)+1: width of `count`; derived, not overridden.

- `clock`  input  1  single system clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `push`  input  1  write `data_in` as the new top this cycle.
- `pop`  input  1  discard the current top this cycle.
- `clear`  input  1  synchronous flush: empty the stack and clear the error flags; has priority over `push`/`pop`.
- `data_in`  input  8  byte to push, driven by the ALU result.
- `stack_out`  output  8  registered top-of-stack byte; 8'h00 when empty.
- `count`  output  CW  number of valid entries, 0..DEPTH.
- `empty`  output  1  `count == 0`.
- `full`  output  1  `count == DEPTH`.
- `overflow`  output  1  sticky; set by a rejected push.
- `underflow`  output  1  sticky; set by a rejected pop.

## Operation
- Storage: `DEPTH`-entry byte array plus a registered top copy (`stack_out`), so the ALU sees the top with no array read in its path.
- Commands, evaluated each rising edge in priority order:
  - `clear`: count←0, `stack_out`←0, `overflow`←0, `underflow`←0; array contents don't care.
  - `push & pop`, count ≥ 1: replace the top. Array[count-1]←`data_in`, `stack_out`←`data_in`, count unchanged. This is legal when full.
  - `push & pop`, count == 0: perform a push only (count←1, `stack_out`←`data_in`) and set `underflow`.
  - `push` only, count < DEPTH: array[count]←`data_in`, count←count+1, `stack_out`←`data_in`.
  - `push` only, count == DEPTH: no state change except `overflow`←1. `stack_out` holds its value.
  - `pop` only, count ≥ 2: count←count-1, `stack_out`←array[count-2].
  - `pop` only, count == 1: count←0, `stack_out`←0.
  - `pop` only, count == 0: no change except `underflow`←1.
  - No command: hold.
- `overflow` and `underflow` stay set until `clear` or reset. They never block later legal operations.
- `count` is an unsigned CW-bit value. It never wraps: it saturates by rejection at 0 and at DEPTH.
- `empty` and `full` are decoded combinationally from the `count` register.

## Timing
- Reset (`reset_n` low, asynchronous): count=0, `stack_out`=8'h00, `empty`=1, `full`=0, `overflow`=0, `underflow`=0. The array is not reset.
- Release of `reset_n` is synchronised by the system. The first command is accepted on the first rising edge after `reset_n` goes high.
- Latency: every command takes effect on the next rising edge. `stack_out`, `count` and the flags show the new value in the cycle after the command.
- Pushed data is readable on `stack_out` one cycle after `push`. This allows back-to-back push→ALU-read→push sequences.
- Pop latency is one cycle. The byte below the top appears on `stack_out` the cycle after `pop`.
- There is no handshake: the control unit must qualify `push`/`pop` itself. Illegal commands are absorbed and reported via the flags only.
- Reset asserted mid-operation: all outputs return to their reset values immediately. Any in-flight command is lost.

## Test plan
- Reset, then push 8'hA1, 8'hB2, 8'hC3 on consecutive cycles:
  - `stack_out` goes A1, B2, C3 one cycle after each push.
  - `count` goes 1, 2, 3.
  - Then pop three times: `stack_out` goes B2, A1, 00 and `empty`=1.
- Fill to DEPTH=16 with 8'h00..8'h0F:
  - `full`=1 and `stack_out`=0F.
  - A 17th push of 8'hFF: `overflow`=1, `count`=16, `stack_out`=0F.
  - Then push+pop with 8'h55: `stack_out`=55, `count`=16.
- On an empty stack, pop: `underflow`=1, `count`=0, `stack_out`=00.
  - Then push+pop with 8'h7E: `count`=1, `stack_out`=7E, and `underflow` stays 1.
- With `count`=5, assert `clear`+`push` together: `count`=0, `stack_out`=00, both flags 0. The push is ignored.
- Assert `reset_n` low asynchronously, mid-cycle, with `count`=3 and `overflow`=1:
  - All outputs take reset values before the next clock edge.
  - The first push after release gives `count`=1.
